// File: rtl/ldtu_stream_decoder.sv
// LiTE-DTU receive-side stream decoder: classifies 32-bit words and unpacks baseline/signal samples.
// Optional trailer sample-count check is enabled by defining LDTU_DEC_FRAMECHECK_EN.
module ldtu_stream_decoder #(
  parameter int Nbits_32   = 32,
  parameter int Nbits_12   = 12,
  parameter int ErrCntBits = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [Nbits_32-1:0]   synch_pattern,
  input  logic [Nbits_32-1:0]   word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [Nbits_12:0]     sample_out,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  frame_end,
  output logic                  frame_error,
  output logic                  invalid_word,
  output logic                  synch_seen,
  output logic [ErrCntBits-1:0] err_count
);

  localparam logic [ErrCntBits-1:0] ERR_MAX = {ErrCntBits{1'b1}};
  localparam logic [ErrCntBits-1:0] ERR_ONE = {{(ErrCntBits-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, UNPACK = 1'b1} state_t;

  state_t      state_r;
  logic [29:0] word_r;
  logic        base_r;
  logic [2:0]  idx_r;
  logic [2:0]  rem_r;

  logic        is_synch_s;
  logic        is_base_s;
  logic        is_data_s;
  logic        is_trl_s;
  logic        is_inv_s;
  logic [2:0]  n_s;
  logic        accept_s;
  logic        load_s;
  logic        last_s;
  logic        mismatch_s;
  logic        err_inc_s;

  function automatic logic [Nbits_12:0] sample_of(input logic [29:0] w, input logic base,
                                                  input logic [2:0] idx);
    logic [5:0] b;
    case (idx)
      3'd0:    b = w[5:0];
      3'd1:    b = w[11:6];
      3'd2:    b = w[17:12];
      3'd3:    b = w[23:18];
      3'd4:    b = w[29:24];
      default: b = 6'd0;
    endcase
    if (base) begin
      sample_of = {{(Nbits_12-5){1'b0}}, b};
    end else if (idx == 3'd0) begin
      sample_of = w[12:0];
    end else begin
      sample_of = w[25:13];
    end
  endfunction

  // Word classification in priority order; n_s is the number of samples a data word carries.
  always_comb begin
    is_synch_s = 1'b0;
    is_base_s  = 1'b0;
    is_data_s  = 1'b0;
    is_trl_s   = 1'b0;
    is_inv_s   = 1'b0;
    n_s        = 3'd0;
    if (word_in == synch_pattern) begin
      is_synch_s = 1'b1;
    end else if (word_in[31:30] == 2'b01) begin
      is_base_s = 1'b1;
      is_data_s = 1'b1;
      n_s       = 3'd5;
    end else if (word_in[31:26] == 6'b001010) begin
      is_data_s = 1'b1;
      n_s       = 3'd2;
    end else if (word_in[31:26] == 6'b001011) begin
      is_data_s = 1'b1;
      n_s       = 3'd1;
    end else if (word_in[31:28] == 4'b1101) begin
      is_trl_s = 1'b1;
    end else begin
      is_inv_s = 1'b1;
    end
  end

  assign last_s     = (rem_r == 3'd1);
  assign word_ready = (state_r == IDLE) || ((state_r == UNPACK) && last_s && sample_ready);
  assign accept_s   = word_valid && word_ready;
  assign load_s     = accept_s && is_data_s;
  assign err_inc_s  = accept_s && (is_inv_s || (is_trl_s && mismatch_s));

`ifdef LDTU_DEC_FRAMECHECK_EN
  logic [7:0] frame_cnt_r;

  // Running sample count of the current frame, cleared by each trailer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_cnt_r <= 8'd0;
    end else if (accept_s && is_trl_s) begin
      frame_cnt_r <= 8'd0;
    end else if (load_s) begin
      frame_cnt_r <= frame_cnt_r + {5'd0, n_s};
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign mismatch_s = (word_in[7:0] != frame_cnt_r);
`else
  assign mismatch_s = 1'b0;
`endif

  // Unpack FSM with registered sample output, status pulses and saturating error counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= IDLE;
      word_r       <= 30'd0;
      base_r       <= 1'b0;
      idx_r        <= 3'd0;
      rem_r        <= 3'd0;
      sample_out   <= {(Nbits_12+1){1'b0}};
      sample_valid <= 1'b0;
      frame_end    <= 1'b0;
      frame_error  <= 1'b0;
      invalid_word <= 1'b0;
      synch_seen   <= 1'b0;
      err_count    <= {ErrCntBits{1'b0}};
    end else begin
      frame_end    <= accept_s && is_trl_s;
      frame_error  <= accept_s && is_trl_s && mismatch_s;
      invalid_word <= accept_s && is_inv_s;
      synch_seen   <= accept_s && is_synch_s;
      if (err_inc_s && (err_count != ERR_MAX)) begin
        err_count <= err_count + ERR_ONE;
      end
      if (load_s) begin
        state_r      <= UNPACK;
        word_r       <= word_in[29:0];
        base_r       <= is_base_s;
        idx_r        <= 3'd1;
        rem_r        <= n_s;
        sample_out   <= sample_of(word_in[29:0], is_base_s, 3'd0);
        sample_valid <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            sample_valid <= 1'b0;
          end
          UNPACK: begin
            if (sample_ready && !last_s) begin
              sample_out <= sample_of(word_r, base_r, idx_r);
              idx_r      <= idx_r + 3'd1;
              rem_r      <= rem_r - 3'd1;
            end else if (sample_ready) begin
              state_r      <= IDLE;
              rem_r        <= 3'd0;
              sample_valid <= 1'b0;
            end
          end
          default: begin
            state_r      <= IDLE;
            sample_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ldtu_stream_decoder.sv
// Scoreboard bench for ldtu_stream_decoder: directed cases plus randomized word/backpressure traffic.
module tb_ldtu_stream_decoder;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] synch_pattern;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic [12:0] sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic        frame_end;
  logic        frame_error;
  logic        invalid_word;
  logic        synch_seen;
  logic [7:0]  err_count;

  ldtu_stream_decoder dut (
    .CLK(CLK), .RST(RST), .synch_pattern(synch_pattern),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .frame_end(frame_end), .frame_error(frame_error), .invalid_word(invalid_word),
    .synch_seen(synch_seen), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  bit          started = 1'b0;
  bit          rand_ready = 1'b0;
  bit          stall_prev = 1'b0;
  logic [12:0] held;
  logic [12:0] exp_q[$];
  logic [3:0]  exp_pulse[64];   // {synch, invalid, frame_error, frame_end} expected per cycle slot
  int          model_fcnt = 0;
  int          model_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference behaviour of one accepted word, straight from the word-format rules.
  task automatic model_accept(input logic [31:0] w);
    logic [3:0] p = 4'd0;
    if (w == synch_pattern) begin
      p[3] = 1'b1;
    end else if (w[31:30] == 2'b01) begin
      for (int k = 0; k < 5; k++) exp_q.push_back(13'((w >> (6 * k)) & 32'h3F));
      model_fcnt = (model_fcnt + 5) % 256;
    end else if (w[31:26] == 6'b001010) begin
      exp_q.push_back(13'(w & 32'h1FFF));
      exp_q.push_back(13'((w >> 13) & 32'h1FFF));
      model_fcnt = (model_fcnt + 2) % 256;
    end else if (w[31:26] == 6'b001011) begin
      exp_q.push_back(13'(w & 32'h1FFF));
      model_fcnt = (model_fcnt + 1) % 256;
    end else if (w[31:28] == 4'b1101) begin
      p[0] = 1'b1;
`ifdef LDTU_DEC_FRAMECHECK_EN
      if (int'(w & 32'hFF) != model_fcnt) begin
        p[1] = 1'b1;
        if (model_err < 255) model_err++;
      end
`endif
      model_fcnt = 0;
    end else begin
      p[2] = 1'b1;
      if (model_err < 255) model_err++;
    end
    exp_pulse[(cyc + 1) % 64] = p;
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Stimulus observer: every accepted word feeds the reference model.
  always @(negedge CLK) begin
    if (started && !RST && word_valid && word_ready) model_accept(word_in);
  end

  // Monitor: pulses, output hold under backpressure, and sample scoreboard.
  always @(negedge CLK) begin
    if (started && !RST) begin
      chk("pulses", {28'd0, synch_seen, invalid_word, frame_error, frame_end}, {28'd0, exp_pulse[cyc % 64]});
      exp_pulse[cyc % 64] = 4'd0;
      if (stall_prev) begin
        chk("hold_valid", {31'd0, sample_valid}, 32'd1);
        chk("hold_data", {19'd0, sample_out}, {19'd0, held});
      end
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) chk("unexpected_sample", {19'd0, sample_out}, 32'hFFFFFFFF);
        else chk("sample", {19'd0, sample_out}, {19'd0, exp_q.pop_front()});
      end
      stall_prev = sample_valid && !sample_ready;
      held = sample_out;
    end else begin
      stall_prev = 1'b0;
    end
  end

  always @(posedge CLK) begin
    #1;
    if (rand_ready) sample_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic flush_model();
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_pulse[i] = 4'd0;
    model_fcnt = 0;
    model_err = 0;
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    word_valid = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
    RST = 1'b0;
    flush_model();
  endtask

  task automatic send(input logic [31:0] w);
    bit ok = 1'b0;
    word_in = w;
    word_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge CLK);
      if (word_ready) ok = 1'b1;
    end
    chk("send_accepted", {31'd0, ok}, 32'd1);
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && (exp_q.size() != 0 || sample_valid); t++) @(negedge CLK);
    chk("drain_empty", exp_q.size(), 32'd0);
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    word_valid = 1'b0;
    word_in = 32'd0;
    sample_ready = 1'b1;
    synch_pattern = 32'h5A5A5A5A;
    do_reset(3);
    started = 1'b1;
    @(negedge CLK);
    chk("rst_word_ready", {31'd0, word_ready}, 32'd1);
    chk("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_sample_out", {19'd0, sample_out}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);

    // Baseline word: five samples, word_ready low while unpacking.
    @(posedge CLK); #1;
    send(32'h45103081);
    word_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("busy_word_ready", {31'd0, word_ready}, 32'd0);
    end
    @(negedge CLK);
    chk("last_word_ready", {31'd0, word_ready}, 32'd1);
    @(posedge CLK); #1;

    // Signal word and matching trailer back-to-back.
    send(32'h2BFFE123);
    send(32'hD0000007);
    word_valid = 1'b0;
    drain();
    chk("frame_ok_err", {24'd0, err_count}, model_err);

    // Mismatching trailer after seven samples.
    send(32'h45103081);
    send(32'h2BFFE123);
    send(32'hD0000003);
    word_valid = 1'b0;
    drain();
    chk("frame_bad_err", {24'd0, err_count}, model_err);

    // Synch word and an invalid word.
    send(32'h5A5A5A5A);
    send(32'h00000000);
    word_valid = 1'b0;
    drain();
    chk("synch_inv_err", {24'd0, err_count}, model_err);

    // Backpressure hold, then reset in the middle of unpacking.
    @(posedge CLK); #1;
    sample_ready = 1'b0;
    send(32'h45103081);
    word_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("stall_valid", {31'd0, sample_valid}, 32'd1);
      chk("stall_sample", {19'd0, sample_out}, 32'h001);
      chk("stall_word_ready", {31'd0, word_ready}, 32'd0);
    end
    @(posedge CLK); #1;
    sample_ready = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    do_reset(1);
    @(negedge CLK);
    chk("midrst_valid", {31'd0, sample_valid}, 32'd0);
    chk("midrst_word_ready", {31'd0, word_ready}, 32'd1);
    chk("midrst_err", {24'd0, err_count}, 32'd0);

    // Error counter saturation.
    @(posedge CLK); #1;
    for (int i = 0; i < 300; i++) send(32'hE0000000 | i);
    word_valid = 1'b0;
    drain();
    chk("err_sat", {24'd0, err_count}, 32'd255);
    chk("err_sat_model", {24'd0, err_count}, model_err);

    // Randomized traffic with random backpressure and idle gaps.
    @(posedge CLK); #1;
    do_reset(1);
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      case ($urandom_range(0, 9))
        0:       w = 32'h5A5A5A5A;
        1, 2, 3: w = {2'b01, 30'($urandom)};
        4, 5:    w = {6'b001010, 26'($urandom)};
        6:       w = {6'b001011, 26'($urandom)};
        7:       w = {4'b1101, 20'($urandom),
                      ($urandom_range(0, 1) != 0) ? 8'(model_fcnt) : 8'($urandom)};
        8:       w = {4'b1110, 28'($urandom)};
        default: w = {4'b1000, 28'($urandom)};
      endcase
      send(w);
      if ($urandom_range(0, 3) == 0) begin
        word_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
      end
    end
    word_valid = 1'b0;
    drain();
    chk("random_err", {24'd0, err_count}, model_err);
    rand_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
